// File: rtl/cpu_types_pkg.sv
// Shared CPU decode constants and control-unit state encodings.
// Opcodes live in instr[31:26]; R-type functs live in instr[5:0].
// pc_ctrl_state_t is the next-PC control state machine encoding.
package cpu_types_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pc_ctrl_state_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Select encodings for the datapath multiplexers.
// pc_mux_input_selection picks the next-PC source for the pc block:
//   SEL_NPC = PC+4, SEL_BRANCH = PC+4+offset, SEL_JUMP = jump index, SEL_JR = rs.
package data_path_muxs_pkg;

  typedef enum logic [1:0] {
    SEL_NPC    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JR     = 2'd3
  } pc_mux_input_selection;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bundle of the next-PC control unit signals for hierarchical hookup.
// Ports: CLK in; pc_ctrl modport drives PCSrc/load_*/jr_addr/pc_wait/imemREN/
//        halted/counters from the fetch/decode/memory inputs; tb modport is the mirror.
interface pc_ctrl_if #(
  parameter int CNT_W = 32
) (
  input logic CLK
);
  logic             nRST;
  logic             ihit;
  logic             dhit;
  logic [31:0]      instr;
  logic             dmemREN;
  logic             dmemWEN;
  logic             zero;
  logic [31:0]      rs_data;
  logic [1:0]       PCSrc;
  logic [25:0]      load_addr;
  logic [15:0]      load_imm;
  logic [31:0]      jr_addr;
  logic             pc_wait;
  logic             imemREN;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport pc_ctrl (
    input  CLK, nRST, ihit, dhit, instr, dmemREN, dmemWEN, zero, rs_data,
    output PCSrc, load_addr, load_imm, jr_addr, pc_wait, imemREN, halted,
           instr_cnt, stall_cnt
  );

  modport tb (
    input  CLK, PCSrc, load_addr, load_imm, jr_addr, pc_wait, imemREN, halted,
           instr_cnt, stall_cnt,
    output nRST, ihit, dhit, instr, dmemREN, dmemWEN, zero, rs_data
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, never wraps.
// Ports: CLK clock; nRST synchronous active-low clear; en count enable;
//        count current value (registered).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC control: decodes PC source and runs the RUN/MEM_WAIT/HALT stall FSM.
// Ports: CLK, nRST (sync, active-low); ihit/dhit memory handshakes; instr, dmemREN/WEN,
//        zero, rs_data decode inputs; PCSrc, load_addr/imm, jr_addr, pc_wait, imemREN,
//        halted, instr_cnt/stall_cnt outputs.
module pc_ctrl
  import data_path_muxs_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      instr,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  output logic [1:0]       PCSrc,
  output logic [25:0]      load_addr,
  output logic [15:0]      load_imm,
  output logic [31:0]      jr_addr,
  output logic             pc_wait,
  output logic             imemREN,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pc_ctrl_state_t        state, next_state;
  pc_mux_input_selection pc_sel;
  logic [5:0]            opcode;
  logic [5:0]            funct;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign load_addr = instr[25:0];
  assign load_imm  = instr[15:0];
  assign jr_addr   = rs_data;

  // HALT is absorbing, so the state itself is the sticky flag.
  assign halted    = (state == HALT);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_wait    = 1'b1;
    imemREN    = 1'b0;

    unique case (state)
      RUN: begin
        imemREN = 1'b1;
        if (ihit) begin
          // Halt wins over any memory access encoded in the same word.
          if (opcode == OP_HALT) begin
            next_state = HALT;
          end else if (dmemREN || dmemWEN) begin
            if (dhit) begin
              pc_wait = 1'b0;
            end else begin
              next_state = MEM_WAIT;
            end
          end else begin
            pc_wait = 1'b0;
          end
        end
      end
      MEM_WAIT: begin
        // Fetch is parked; instr is held by the pipeline while we wait.
        pc_wait = ~dhit;
        if (dhit) begin
          next_state = RUN;
        end
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = RUN;
      end
    endcase

    if (!nRST) begin
      pc_wait    = 1'b1;
      imemREN    = 1'b0;
      next_state = RUN;
    end
  end

  // PC source only matters when the PC actually advances.
  always_comb begin
    pc_sel = SEL_NPC;
    if (!pc_wait) begin
      if ((opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero)) begin
        pc_sel = SEL_BRANCH;
      end else if (opcode == OP_J || opcode == OP_JAL) begin
        pc_sel = SEL_JUMP;
      end else if (opcode == OP_RTYPE && funct == FN_JR) begin
        pc_sel = SEL_JR;
      end
    end
  end

  assign PCSrc = pc_sel;

  logic instr_en, stall_en;
  assign instr_en = nRST && !pc_wait;
  assign stall_en = nRST && pc_wait && (state != HALT);

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (instr_en),
    .count (instr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (stall_en),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed vectors push expectations, a negedge monitor
// pops and compares. A second instance with CNT_W=4 exercises counter saturation.
module tb_pc_ctrl;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, dmemREN, dmemWEN, zero;
  logic [31:0] instr, rs_data;
  logic [1:0]  PCSrc;
  logic [25:0] load_addr;
  logic [15:0] load_imm;
  logic [31:0] jr_addr;
  logic        pc_wait, imemREN, halted;
  logic [31:0] instr_cnt, stall_cnt;

  // saturation instance signals
  logic        s_nRST;
  logic [1:0]  s_PCSrc;
  logic [25:0] s_load_addr;
  logic [15:0] s_load_imm;
  logic [31:0] s_jr_addr;
  logic        s_pc_wait, s_imemREN, s_halted;
  logic [3:0]  s_instr_cnt, s_stall_cnt;

  localparam logic [31:0] ADDIU = 32'h2401_0001;
  localparam logic [31:0] BEQ   = 32'h1085_0003;
  localparam logic [31:0] BNE   = 32'h1485_FFFE;
  localparam logic [31:0] JMP   = 32'h0800_0010;
  localparam logic [31:0] JR    = 32'h03E0_0008;
  localparam logic [31:0] LW    = 32'h8C82_0000;
  localparam logic [31:0] HLT   = 32'hFFFF_FFFF;

  always #5 CLK = ~CLK;

  pc_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .instr(instr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .zero(zero), .rs_data(rs_data),
    .PCSrc(PCSrc), .load_addr(load_addr), .load_imm(load_imm), .jr_addr(jr_addr),
    .pc_wait(pc_wait), .imemREN(imemREN), .halted(halted),
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  pc_ctrl #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(s_nRST), .ihit(1'b1), .dhit(1'b0), .instr(ADDIU),
    .dmemREN(1'b0), .dmemWEN(1'b0), .zero(1'b0), .rs_data(32'h0),
    .PCSrc(s_PCSrc), .load_addr(s_load_addr), .load_imm(s_load_imm), .jr_addr(s_jr_addr),
    .pc_wait(s_pc_wait), .imemREN(s_imemREN), .halted(s_halted),
    .instr_cnt(s_instr_cnt), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    int          step;
    logic        pw, im, hl, ck;
    logic [1:0]  src;
    logic [31:0] ic, sc;
    logic [31:0] ins, rs;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  sat_q[$];
  int          errors = 0;
  int          checks = 0;
  int          step_no = 0;
  int          sat_steps = 0;

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", nm, step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue its expected response.
  task automatic v(input logic rst, ih, dh, ren, wen, z, input logic [31:0] ins, rs,
                   input logic pw, im, input logic [1:0] src, input logic hl,
                   input logic ck, input logic [31:0] ic, sc);
    exp_t e;
    @(posedge CLK);
    #1;
    step_no++;
    nRST = rst; ihit = ih; dhit = dh; dmemREN = ren; dmemWEN = wen; zero = z;
    instr = ins; rs_data = rs;
    // saturation instance: reset for the first two steps, then free-running
    s_nRST = (step_no > 2);
    if (step_no >= 2) begin
      sat_q.push_back((step_no - 3 > 15 || step_no < 3) ?
                      ((step_no < 3) ? 4'd0 : 4'hF) : 4'(step_no - 3));
      sat_steps++;
    end
    e.step = step_no; e.pw = pw; e.im = im; e.src = src; e.hl = hl; e.ck = ck;
    e.ic = ic; e.sc = sc; e.ins = ins; e.rs = rs;
    sb.push_back(e);
  endtask

  // Monitor: outputs and counters are sampled mid-cycle, away from the edge.
  initial begin
    exp_t e;
    logic [3:0] se;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_wait",   e.step, {31'b0, pc_wait}, {31'b0, e.pw});
        chk("imemREN",   e.step, {31'b0, imemREN}, {31'b0, e.im});
        chk("PCSrc",     e.step, {30'b0, PCSrc},   {30'b0, e.src});
        chk("halted",    e.step, {31'b0, halted},  {31'b0, e.hl});
        chk("load_addr", e.step, {6'b0, load_addr}, {6'b0, e.ins[25:0]});
        chk("load_imm",  e.step, {16'b0, load_imm}, {16'b0, e.ins[15:0]});
        chk("jr_addr",   e.step, jr_addr, e.rs);
        if (e.ck) begin
          chk("instr_cnt", e.step, instr_cnt, e.ic);
          chk("stall_cnt", e.step, stall_cnt, e.sc);
        end
      end
      if (sat_q.size() > 0) begin
        se = sat_q.pop_front();
        chk("sat_instr_cnt", step_no, {28'b0, s_instr_cnt}, {28'b0, se});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog step=%0d got=timeout expected=finish", step_no);
    $fatal(1, "bench timeout");
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    zero = 1'b0; instr = ADDIU; rs_data = 32'h0; s_nRST = 1'b0;

    //  rst ih dh rn wn z  instr  rs        pw im src  hl ck  ic  sc
    v(0, 1, 0, 0, 0, 0, ADDIU, 32'h0,  1, 0, 2'd0, 0, 0, 0, 0);   // 1 reset
    v(0, 1, 0, 0, 0, 0, ADDIU, 32'h0,  1, 0, 2'd0, 0, 1, 0, 0);   // 2 reset, cnt 0
    v(1, 1, 0, 0, 0, 0, ADDIU, 32'h0,  0, 1, 2'd0, 0, 1, 0, 0);   // 3 release
    v(1, 1, 0, 0, 0, 1, BEQ,   32'h0,  0, 1, 2'd1, 0, 1, 1, 0);   // 4 BEQ taken
    v(1, 1, 0, 0, 0, 0, BEQ,   32'h0,  0, 1, 2'd0, 0, 1, 2, 0);   // 5 BEQ not taken
    v(1, 1, 0, 0, 0, 0, BNE,   32'h0,  0, 1, 2'd1, 0, 1, 3, 0);   // 6 BNE taken
    v(1, 1, 0, 0, 0, 0, JMP,   32'h0,  0, 1, 2'd2, 0, 1, 4, 0);   // 7 J
    v(1, 1, 0, 0, 0, 0, JR,    32'h40, 0, 1, 2'd3, 0, 1, 5, 0);   // 8 JR
    v(1, 0, 0, 0, 0, 0, JMP,   32'h0,  1, 1, 2'd0, 0, 1, 6, 0);   // 9 no ihit
    v(1, 1, 0, 1, 0, 0, LW,    32'h0,  1, 1, 2'd0, 0, 1, 6, 1);   // 10 LW miss
    v(1, 1, 0, 1, 0, 0, LW,    32'h0,  1, 0, 2'd0, 0, 1, 6, 2);   // 11 MEM_WAIT
    v(1, 0, 0, 1, 0, 0, LW,    32'h0,  1, 0, 2'd0, 0, 1, 6, 3);   // 12 MEM_WAIT
    v(1, 1, 0, 1, 0, 0, LW,    32'h0,  1, 0, 2'd0, 0, 1, 6, 4);   // 13 MEM_WAIT
    v(1, 0, 1, 1, 0, 0, LW,    32'h0,  0, 0, 2'd0, 0, 1, 6, 5);   // 14 dhit
    v(1, 1, 0, 0, 0, 0, ADDIU, 32'h0,  0, 1, 2'd0, 0, 1, 7, 5);   // 15 back in RUN
    v(1, 1, 1, 1, 0, 0, LW,    32'h0,  0, 1, 2'd0, 0, 1, 8, 5);   // 16 LW hit
    v(1, 1, 0, 0, 0, 0, ADDIU, 32'h0,  0, 1, 2'd0, 0, 1, 9, 5);   // 17 still RUN
    v(1, 1, 0, 0, 1, 0, HLT,   32'h0,  1, 1, 2'd0, 0, 1, 10, 5);  // 18 halt+store
    for (int i = 0; i < 10; i++) begin
      v(1, 1, 1, 0, 0, 0, ADDIU, 32'h0, 1, 0, 2'd0, 1, 1, 10, 6); // 19..28 HALT
    end
    v(0, 1, 0, 0, 0, 0, ADDIU, 32'h0,  1, 0, 2'd0, 1, 1, 10, 6);  // 29 reset in HALT
    v(1, 1, 0, 0, 0, 0, ADDIU, 32'h0,  0, 1, 2'd0, 0, 1, 0, 0);   // 30 RUN again
    v(1, 1, 0, 1, 0, 0, LW,    32'h0,  1, 1, 2'd0, 0, 1, 1, 0);   // 31 LW miss
    v(0, 1, 0, 1, 0, 0, LW,    32'h0,  1, 0, 2'd0, 0, 1, 1, 1);   // 32 reset in MEM_WAIT
    v(1, 1, 0, 0, 0, 0, ADDIU, 32'h0,  0, 1, 2'd0, 0, 1, 0, 0);   // 33 RUN again
    v(1, 1, 0, 0, 0, 0, ADDIU, 32'h0,  0, 1, 2'd0, 0, 1, 1, 0);   // 34

    @(posedge CLK);
    #1;
    chk("sb_drained", step_no, sb.size(), 0);
    chk("sat_drained", step_no, sat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
